// File: rtl/ahb_gpio_pkg.sv
// Shared definitions for the AHB-Lite GPIO peripheral: register offsets,
// edge-type encoding and the AHB transfer-type encoding.
package ahb_gpio_pkg;

  localparam logic [7:0] OFF_DATA   = 8'h00;
  localparam logic [7:0] OFF_DIR    = 8'h04;
  localparam logic [7:0] OFF_IEN    = 8'h08;
  localparam logic [7:0] OFF_ITYPE  = 8'h0C;
  localparam logic [7:0] OFF_STATUS = 8'h10;
  localparam logic [7:0] OFF_CTRL   = 8'h14;

  typedef enum logic {
    EDGE_RISE = 1'b0,
    EDGE_FALL = 1'b1
  } edge_type_t;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  // A transfer is real only for NONSEQ or SEQ; IDLE and BUSY carry no data.
  function automatic logic trans_active(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Input synchroniser chain followed by a previous-value register, giving the
// synchronised vector and single-cycle rise/fall pulses for every bit.
module gpio_sync_edge #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         HCLK,
  input  logic         HRESET,
  input  logic [W-1:0] din,
  output logic [W-1:0] sync,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] chain [STAGES];
  logic [W-1:0] prev;

  // Shift raw pins through the synchroniser; prev always tracks the synchronised value so direction changes never fake an edge.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int i = 0; i < STAGES; i++) begin
        chain[i] <= '0;
      end
      prev <= '0;
    end else begin
      chain[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
      prev <= chain[STAGES-1];
    end
  end

  assign sync = chain[STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/ahb_gpio_param.sv
// AHB-Lite GPIO slave: bus decode, register file, sticky edge status with
// set-over-clear priority, output parity generation, input parity checking
// and the read-data mux.
module ahb_gpio_param
  import ahb_gpio_pkg::*;
#(
  parameter int          WIDTH       = 16,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h5300_0000
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             HSEL,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic             HREADY,
  input  logic [31:0]      HWDATA,
  output logic             HREADYOUT,
  output logic [31:0]      HRDATA,
  input  logic [WIDTH:0]   GPIOIN,
  output logic [WIDTH:0]   GPIOOUT,
  output logic [WIDTH-1:0] GPIOEN,
  output logic             IRQ,
  output logic             PARITYERR
);

  logic             addr_valid;
  logic             dp_valid;
  logic             dp_write;
  logic [7:0]       dp_off;
  logic             wr_en;

  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] dir_reg;
  logic [WIDTH-1:0] ien_reg;
  logic [WIDTH-1:0] itype_reg;
  logic [WIDTH-1:0] status_reg;
  logic             podd_reg;
  logic             irq_reg;
  logic             perr_reg;

  logic [WIDTH:0]   sync_in;
  logic [WIDTH:0]   rise_all;
  logic [WIDTH:0]   fall_all;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] status_clr;
  logic [31:0]      rdata;

  // The region is chosen by HSEL; BASE_ADDR and the upper address bits only
  // matter to the system decoder, and the parity pin carries no edge events.
  logic unused_ok;
  assign unused_ok = ^{rise_all[WIDTH], fall_all[WIDTH], HADDR[31:8],
                       HWDATA[31:WIDTH], BASE_ADDR};

  gpio_sync_edge #(
    .W      (WIDTH + 1),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .din    (GPIOIN),
    .sync   (sync_in),
    .rise   (rise_all),
    .fall   (fall_all)
  );

  assign addr_valid = HSEL & HREADY & trans_active(HTRANS);
  assign wr_en      = dp_valid & dp_write;

  // Capture the address phase so the following cycle knows what to write or read.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_off   <= '0;
    end else begin
      dp_valid <= addr_valid;
      dp_write <= HWRITE;
      dp_off   <= HADDR[7:0];
    end
  end

  // Plain configuration registers take HWDATA at the end of the data phase.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      out_reg   <= '0;
      dir_reg   <= '0;
      ien_reg   <= '0;
      itype_reg <= '0;
      podd_reg  <= 1'b0;
    end else if (wr_en) begin
      case (dp_off)
        OFF_DATA:  out_reg   <= HWDATA[WIDTH-1:0];
        OFF_DIR:   dir_reg   <= HWDATA[WIDTH-1:0];
        OFF_IEN:   ien_reg   <= HWDATA[WIDTH-1:0];
        OFF_ITYPE: itype_reg <= HWDATA[WIDTH-1:0];
        OFF_CTRL:  podd_reg  <= HWDATA[0];
        default: ;
      endcase
    end
  end

  // Pick the selected edge polarity per pin, only for pins configured as inputs.
  always_comb begin
    edge_set = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!dir_reg[i]) begin
        edge_set[i] = (edge_type_t'(itype_reg[i]) == EDGE_FALL) ? fall_all[i] : rise_all[i];
      end
    end
  end

  assign status_clr = (wr_en && (dp_off == OFF_STATUS)) ? HWDATA[WIDTH-1:0] : '0;

  // Sticky status: clear first, then OR in new edges so a coincident edge survives the W1C.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      status_reg <= '0;
    end else begin
      status_reg <= (status_reg & ~status_clr) | edge_set;
    end
  end

  // Register the interrupt and the input parity check so both outputs are glitch-free.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      irq_reg  <= 1'b0;
      perr_reg <= 1'b0;
    end else begin
      irq_reg  <= |(status_reg & ien_reg);
      perr_reg <= (^sync_in) ^ podd_reg;
    end
  end

  // Read data is driven only during a valid data phase and zero elsewhere.
  always_comb begin
    rdata = '0;
    if (dp_valid) begin
      case (dp_off)
        OFF_DATA:   rdata[WIDTH-1:0] = (out_reg & dir_reg) | (sync_in[WIDTH-1:0] & ~dir_reg);
        OFF_DIR:    rdata[WIDTH-1:0] = dir_reg;
        OFF_IEN:    rdata[WIDTH-1:0] = ien_reg;
        OFF_ITYPE:  rdata[WIDTH-1:0] = itype_reg;
        OFF_STATUS: rdata[WIDTH-1:0] = status_reg;
        OFF_CTRL:   rdata[0]         = podd_reg;
        default:    rdata            = '0;
      endcase
    end
  end

  assign HRDATA    = rdata;
  assign HREADYOUT = 1'b1;
  assign GPIOOUT   = {(^out_reg) ^ podd_reg, out_reg & dir_reg};
  assign GPIOEN    = dir_reg;
  assign IRQ       = irq_reg;
  assign PARITYERR = perr_reg;

endmodule

// File: tb/tb_ahb_gpio_param.sv
// Scoreboard bench for ahb_gpio_param: stimulus pushes expectations tagged
// with the cycle they are due, a negedge monitor pops and compares them.
module tb_ahb_gpio_param;

  localparam int          WIDTH = 16;
  localparam int          SYNC  = 2;
  localparam logic [31:0] BASE  = 32'h5300_0000;

  localparam int SEL_RD   = 0;
  localparam int SEL_OUT  = 1;
  localparam int SEL_EN   = 2;
  localparam int SEL_IRQ  = 3;
  localparam int SEL_PERR = 4;
  localparam int SEL_RDY  = 5;

  logic             HCLK = 1'b0;
  logic             HRESET;
  logic             HSEL;
  logic [31:0]      HADDR;
  logic [1:0]       HTRANS;
  logic             HWRITE;
  logic             HREADY;
  logic [31:0]      HWDATA;
  logic             HREADYOUT;
  logic [31:0]      HRDATA;
  logic [WIDTH:0]   GPIOIN;
  logic [WIDTH:0]   GPIOOUT;
  logic [WIDTH-1:0] GPIOEN;
  logic             IRQ;
  logic             PARITYERR;

  typedef struct {
    int          due;
    int          sel;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t scb[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  logic [WIDTH-1:0] m_out, m_dir, m_ien, m_itype, m_status;
  logic             m_podd;
  logic [WIDTH:0]   m_pins;

  ahb_gpio_param #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC),
    .BASE_ADDR   (BASE)
  ) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HREADY    (HREADY),
    .HWDATA    (HWDATA),
    .HREADYOUT (HREADYOUT),
    .HRDATA    (HRDATA),
    .GPIOIN    (GPIOIN),
    .GPIOOUT   (GPIOOUT),
    .GPIOEN    (GPIOEN),
    .IRQ       (IRQ),
    .PARITYERR (PARITYERR)
  );

  // Free-running bus clock.
  always #5 HCLK = ~HCLK;

  // Edge counter used to time every expectation.
  always @(posedge HCLK) cyc <= cyc + 1;

  function automatic logic [31:0] probe(input int sel);
    logic [31:0] v;
    v = '0;
    case (sel)
      SEL_RD:   v = HRDATA;
      SEL_OUT:  v[WIDTH:0] = GPIOOUT;
      SEL_EN:   v[WIDTH-1:0] = GPIOEN;
      SEL_IRQ:  v[0] = IRQ;
      SEL_PERR: v[0] = PARITYERR;
      SEL_RDY:  v[0] = HREADYOUT;
      default:  v = '1;
    endcase
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare every expectation that falls due in this cycle.
  always @(negedge HCLK) begin
    for (int i = scb.size() - 1; i >= 0; i--) begin
      if (scb[i].due == cyc) begin
        checkOutput(scb[i].name, probe(scb[i].sel), scb[i].exp);
        scb.delete(i);
      end
    end
  end

  task automatic expectAt(input int due, input int sel, input logic [31:0] exp, input string name);
    chk_t c;
    c.due = due; c.sel = sel; c.exp = exp; c.name = name;
    scb.push_back(c);
  endtask

  // Reference model: register contents as the programmer sees them.
  function automatic logic [31:0] modelRead(input logic [7:0] off);
    logic [31:0] r;
    r = '0;
    case (off)
      8'h00: r[WIDTH-1:0] = (m_dir & m_out) | (~m_dir & m_pins[WIDTH-1:0]);
      8'h04: r[WIDTH-1:0] = m_dir;
      8'h08: r[WIDTH-1:0] = m_ien;
      8'h0C: r[WIDTH-1:0] = m_itype;
      8'h10: r[WIDTH-1:0] = m_status;
      8'h14: r[0] = m_podd;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic modelWrite(input logic [7:0] off, input logic [31:0] d);
    case (off)
      8'h00: m_out = d[WIDTH-1:0];
      8'h04: m_dir = d[WIDTH-1:0];
      8'h08: m_ien = d[WIDTH-1:0];
      8'h0C: m_itype = d[WIDTH-1:0];
      8'h10: m_status = m_status & ~d[WIDTH-1:0];
      8'h14: m_podd = d[0];
      default: ;
    endcase
  endtask

  task automatic modelReset();
    m_out = '0; m_dir = '0; m_ien = '0; m_itype = '0; m_status = '0; m_podd = 1'b0;
  endtask

  // Drive pins and record which input pins saw their selected edge.
  task automatic drivePins(input logic [WIDTH:0] p);
    for (int i = 0; i < WIDTH; i++) begin
      if (!m_dir[i]) begin
        if (!m_itype[i] && p[i] && !m_pins[i]) m_status[i] = 1'b1;
        if (m_itype[i] && !p[i] && m_pins[i]) m_status[i] = 1'b1;
      end
    end
    m_pins = p;
    GPIOIN = p;
  endtask

  task automatic nextCycle();
    @(posedge HCLK);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) nextCycle();
  endtask

  task automatic addrPhase(input logic wr, input logic [7:0] off);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = BASE | {24'h0, off};
  endtask

  task automatic idlePhase();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0;
  endtask

  task automatic busWrite(input logic [7:0] off, input logic [31:0] d);
    addrPhase(1'b1, off);
    nextCycle();
    HWDATA = d;
    idlePhase();
    nextCycle();
    modelWrite(off, d);
  endtask

  task automatic busRead(input logic [7:0] off, input string name);
    addrPhase(1'b0, off);
    expectAt(cyc + 1, SEL_RD, modelRead(off), name);
    nextCycle();
    idlePhase();
    nextCycle();
  endtask

  task automatic busWriteRead(input logic [7:0] woff, input logic [31:0] d, input logic [7:0] roff);
    addrPhase(1'b1, woff);
    nextCycle();
    HWDATA = d;
    modelWrite(woff, d);
    addrPhase(1'b0, roff);
    expectAt(cyc + 1, SEL_RD, modelRead(roff), "b2b_read");
    nextCycle();
    idlePhase();
    nextCycle();
  endtask

  // Steady-state expectations for every non-bus output at this cycle.
  task automatic checkStatic(input string tag);
    logic [31:0] e;
    e = '0;
    e[WIDTH-1:0] = m_out & m_dir;
    e[WIDTH]     = (^m_out) ^ m_podd;
    expectAt(cyc, SEL_OUT, e, {tag, "_gpioout"});
    expectAt(cyc, SEL_EN, {{(32-WIDTH){1'b0}}, m_dir}, {tag, "_gpioen"});
    expectAt(cyc, SEL_IRQ, {31'b0, |(m_status & m_ien)}, {tag, "_irq"});
    expectAt(cyc, SEL_PERR, {31'b0, (^m_pins) ^ m_podd}, {tag, "_perr"});
    expectAt(cyc, SEL_RDY, 32'h1, {tag, "_hreadyout"});
  endtask

  task automatic applyStimulus(input int iters);
    logic [7:0]  off;
    logic [31:0] d;
    for (int n = 0; n < iters; n++) begin
      off = 8'($urandom_range(0, 7) * 4);
      d   = $urandom;
      case ($urandom_range(0, 3))
        0: begin busWrite(off, d); settle(2); end
        1: begin busRead(off, "rnd_read"); settle(2); end
        2: begin drivePins(d[WIDTH:0]); settle(SYNC + 3); end
        default: begin busWriteRead(off, d, off); settle(2); end
      endcase
      checkStatic("rnd");
    end
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    HRESET = 1'b1; HREADY = 1'b1; HWDATA = '0;
    idlePhase();
    m_pins = '0; GPIOIN = '0;
    modelReset();

    // Reset state, held in reset
    settle(2);
    checkStatic("rst");
    expectAt(cyc, SEL_RD, 32'h0, "rst_hrdata");
    nextCycle();
    HRESET = 1'b0;

    // Load some state, then reset in the middle of a DIR write
    busWrite(8'h04, 32'h1234);
    busWrite(8'h00, 32'hFFFF);
    settle(2);
    checkStatic("pre_rst");
    addrPhase(1'b1, 8'h04);
    nextCycle();
    HWDATA = 32'hFFFF;
    idlePhase();
    #2 HRESET = 1'b1;
    nextCycle();
    HRESET = 1'b0;
    modelReset();
    checkStatic("mid_rst");
    busRead(8'h04, "dir_after_rst");

    // DIR then DATA, mixed read-back
    drivePins(17'h0_3C00);
    settle(SYNC + 3);
    busWrite(8'h04, 32'h00FF);
    busWrite(8'h00, 32'hA5A5);
    settle(2);
    checkStatic("data");
    busRead(8'h00, "data_read");

    // Rising edge on pin 0 into STATUS and IRQ, exact timing
    busWrite(8'h04, 32'hFF00);
    busWrite(8'h0C, 32'h0);
    busWrite(8'h08, 32'h1);
    busWrite(8'h10, 32'hFFFF);
    settle(2);
    checkStatic("irq_idle");
    c = cyc;
    drivePins(17'h0_3C01);
    expectAt(c + 3, SEL_IRQ, 32'h0, "irq_early");
    expectAt(c + 4, SEL_IRQ, 32'h1, "irq_set");
    settle(2);
    busRead(8'h10, "status_set");
    c = cyc;
    expectAt(c + 2, SEL_IRQ, 32'h1, "irq_before_clr");
    expectAt(c + 3, SEL_IRQ, 32'h0, "irq_cleared");
    busWrite(8'h10, 32'h1);
    busRead(8'h10, "status_cleared");

    // Edge and W1C on the same bit in the same cycle: set wins
    drivePins(17'h0_3C00);
    settle(SYNC + 3);
    drivePins(17'h0_3C01);
    nextCycle();
    busWrite(8'h10, 32'h1);
    m_status[0] = 1'b1;
    busRead(8'h10, "status_set_wins");
    settle(2);
    checkStatic("set_wins");

    // Odd parity sense and input parity error latency
    busWrite(8'h14, 32'h1);
    drivePins(17'h0_0001);
    settle(SYNC + 3);
    checkStatic("podd");
    c = cyc;
    drivePins(17'h1_0001);
    expectAt(c + SYNC, SEL_PERR, 32'h0, "perr_early");
    expectAt(c + SYNC + 1, SEL_PERR, 32'h1, "perr_set");
    settle(SYNC + 3);
    checkStatic("perr");

    // Back-to-back write/read and an unmapped offset
    busWriteRead(8'h04, 32'h5A5A, 8'h04);
    busRead(8'h18, "unmapped");
    settle(2);
    checkStatic("b2b");

    applyStimulus(80);

    settle(4);
    checks++;
    if (scb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", scb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
